// File: rtl/seg_scan_controller.sv
// Seven-segment scan controller: multiplexes a 16-bit value across NUM_DIGITS
// common-anode digits. Optional feature macro: LEADING_ZERO_BLANK_EN.
module seg_scan_controller #(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 50000,
   parameter int GAP_CYCLES  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic [15:0]           value,
   input  logic                  load,
   output logic                  load_ack,
   output logic [3:0]            nibble,
   output logic [NUM_DIGITS-1:0] anode_n,
   output logic [1:0]            digit_idx,
   output logic                  frame_done
);

   localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
   localparam logic [CW-1:0] CNT_GAP  = CW'(GAP_CYCLES);
   localparam logic [1:0]    IDX_LAST = 2'(NUM_DIGITS - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_GAP   = 2'd1;
   localparam logic [1:0] S_DRIVE = 2'd2;

   logic [1:0]    state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [1:0]    idx_n;
   logic          frame_start;

   logic [15:0]   pend_val, pend_val_n;
   logic          pend_valid, pend_valid_n;
   logic [15:0]   disp_val, disp_n;

   logic [3:0]            nibble_n;
   logic [NUM_DIGITS-1:0] anode_n_n;
   logic [NUM_DIGITS-1:0] show;

   // Slot sequencing: a frame starts on leaving IDLE or on wrapping to slot 0.
   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      idx_n       = digit_idx;
      frame_start = 1'b0;
      if (!en) begin
         state_n = S_IDLE;
         cnt_n   = '0;
         idx_n   = '0;
      end else if (state == S_IDLE) begin
         cnt_n       = '0;
         idx_n       = '0;
         frame_start = 1'b1;
      end else if (cnt == CNT_LAST) begin
         cnt_n       = '0;
         idx_n       = (digit_idx == IDX_LAST) ? 2'd0 : digit_idx + 2'd1;
         frame_start = (digit_idx == IDX_LAST);
      end else begin
         cnt_n = cnt + CW'(1);
      end
      if (en) begin
         state_n = (cnt_n < CNT_GAP) ? S_GAP : S_DRIVE;
      end
   end

   // Double buffer: a load coinciding with the frame start bypasses the pending slot.
   always_comb begin
      disp_n       = disp_val;
      pend_val_n   = pend_val;
      pend_valid_n = pend_valid;
      if (frame_start && load) begin
         disp_n       = value;
         pend_valid_n = 1'b0;
      end else begin
         if (frame_start && pend_valid) begin
            disp_n       = pend_val;
            pend_valid_n = 1'b0;
         end
         if (load) begin
            pend_val_n   = value;
            pend_valid_n = 1'b1;
         end
      end
   end

`ifdef LEADING_ZERO_BLANK_EN
   // Digit k is shown if it or any higher digit is non-zero; digit 0 always shows.
   always_comb begin
      logic upper_nz;
      upper_nz = 1'b0;
      show     = '0;
      for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
         upper_nz = upper_nz | (disp_n[4*k +: 4] != 4'h0);
         show[k]  = upper_nz | (k == 0);
      end
   end
`else
   assign show = '1;
`endif

   // Outputs are computed from next-state values so they line up with cnt/digit_idx.
   always_comb begin
      nibble_n  = nibble;
      anode_n_n = '1;
      if (en) begin
         nibble_n = disp_n[{idx_n, 2'b00} +: 4];
      end
      if (state_n == S_DRIVE && show[idx_n]) begin
         anode_n_n[idx_n] = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         cnt        <= '0;
         digit_idx  <= '0;
         anode_n    <= '1;
         nibble     <= '0;
         load_ack   <= 1'b0;
         frame_done <= 1'b0;
         pend_val   <= '0;
         pend_valid <= 1'b0;
         disp_val   <= '0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         digit_idx  <= idx_n;
         anode_n    <= anode_n_n;
         nibble     <= nibble_n;
         load_ack   <= load;
         frame_done <= frame_start;
         pend_val   <= pend_val_n;
         pend_valid <= pend_valid_n;
         disp_val   <= disp_n;
      end
   end

endmodule

// File: tb/tb_seg_scan_controller.sv
// Directed bench for seg_scan_controller with NUM_DIGITS=4, REFRESH_DIV=8, GAP_CYCLES=2.
module tb_seg_scan_controller;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic [15:0] value = '0;
   logic        load = 1'b0;
   logic        load_ack;
   logic [3:0]  nibble;
   logic [3:0]  anode_n;
   logic [1:0]  digit_idx;
   logic        frame_done;

   int pass_cnt = 0;
   int total_cnt = 0;

   typedef struct {
      logic [15:0] value;
      logic [15:0] nib_seq;   // expected nibbles for slots 0,1,2,3, left to right
      logic [3:0]  lzb_mask;  // digits driven when leading-zero blanking is on
      int          load_cyc;  // frame cycle at which this value is loaded
   } vec_t;

   vec_t vecs[5];

   seg_scan_controller #(
      .NUM_DIGITS (4),
      .REFRESH_DIV(8),
      .GAP_CYCLES (2)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .value     (value),
      .load      (load),
      .load_ack  (load_ack),
      .nibble    (nibble),
      .anode_n   (anode_n),
      .digit_idx (digit_idx),
      .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check(input string name, input int c, input logic [15:0] act, input logic [15:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s cyc=%0d: got %h expected %h", name, c, act, exp);
   endtask

   task automatic run_frame(input logic [15:0] nib_seq, input logic [3:0] lzb_mask,
                            input logic do_load, input int load_cyc, input logic [15:0] load_val,
                            input logic ack0);
      logic [3:0]  mask;
      logic [3:0]  exp_an;
      logic [15:0] seq;
      logic        exp_ack;
      int          d, s;
`ifdef LEADING_ZERO_BLANK_EN
      mask = lzb_mask;
`else
      mask = 4'hF;
`endif
      seq = nib_seq;
      for (int c = 0; c < 32; c++) begin
         d = c / 8;
         s = c % 8;
         exp_an = 4'hF;
         if (s >= 2 && mask[d]) exp_an[d] = 1'b0;
         exp_ack = (c == 0) ? ack0 : (do_load && c == load_cyc + 1);
         check("digit_idx", c, 16'(digit_idx), 16'(d));
         check("nibble", c, 16'(nibble), 16'(seq[15-4*d -: 4]));
         check("anode_n", c, 16'(anode_n), 16'(exp_an));
         check("frame_done", c, 16'(frame_done), 16'(c == 0));
         check("load_ack", c, 16'(load_ack), 16'(exp_ack));
         if (do_load && c == load_cyc) begin
            load  = 1'b1;
            value = load_val;
         end
         tick();
         load = 1'b0;
      end
   endtask

   initial begin
      vecs[0] = '{16'h1A3F, 16'hF3A1, 4'b1111, 0};
      vecs[1] = '{16'h0042, 16'h2400, 4'b0011, 17};
      vecs[2] = '{16'h0000, 16'h0000, 4'b0001, 0};
      vecs[3] = '{16'hBEEF, 16'hFEEB, 4'b1111, 5};
      vecs[4] = '{16'h0100, 16'h0010, 4'b0111, 30};

      repeat (3) tick();
      rst = 1'b0;
      tick();
      check("rst_anode_n", 0, 16'(anode_n), 16'hF);
      check("rst_nibble", 0, 16'(nibble), 16'h0);
      check("rst_digit_idx", 0, 16'(digit_idx), 16'h0);
      check("rst_load_ack", 0, 16'(load_ack), 16'h0);
      check("rst_frame_done", 0, 16'(frame_done), 16'h0);

      // Enable and load together from IDLE: first frame shows the value at once.
      en    = 1'b1;
      load  = 1'b1;
      value = vecs[0].value;
      tick();
      load = 1'b0;

      for (int i = 1; i < 5; i++) begin
         run_frame(vecs[i-1].nib_seq, vecs[i-1].lzb_mask, 1'b1, vecs[i].load_cyc,
                   vecs[i].value, (i == 1));
      end
      run_frame(vecs[4].nib_seq, vecs[4].lzb_mask, 1'b0, 0, 16'h0, 1'b0);

      // Two loads in one frame: the later one wins.
      for (int c = 0; c < 32; c++) begin
         if (c == 3)  begin load = 1'b1; value = 16'h1111; end
         if (c == 10) begin load = 1'b1; value = 16'h2222; end
         tick();
         load = 1'b0;
         if (c == 3 || c == 10) check("lw_load_ack", c + 1, 16'(load_ack), 16'h1);
      end
      // Load on the frame-start edge takes effect in that same frame.
      run_frame(16'h2222, 4'b1111, 1'b1, 31, 16'h3333, 1'b0);
      run_frame(16'h3333, 4'b1111, 1'b0, 0, 16'h0, 1'b1);

      // Drop enable mid-DRIVE of slot 1, load while idle, then re-enable.
      repeat (12) tick();
      check("en_drive_anode", 12, 16'(anode_n), 16'hD);
      en = 1'b0;
      tick();
      check("en_off_anode", 0, 16'(anode_n), 16'hF);
      check("en_off_idx", 0, 16'(digit_idx), 16'h0);
      check("en_off_fd", 0, 16'(frame_done), 16'h0);
      load  = 1'b1;
      value = 16'h5555;
      tick();
      load = 1'b0;
      check("idle_load_ack", 1, 16'(load_ack), 16'h1);
      check("idle_anode", 1, 16'(anode_n), 16'hF);
      repeat (2) tick();
      check("idle_anode_late", 3, 16'(anode_n), 16'hF);
      en = 1'b1;
      tick();
      run_frame(16'h5555, 4'b1111, 1'b0, 0, 16'h0, 1'b0);

      // Asynchronous reset during DRIVE of slot 1, with a pending load.
      repeat (10) tick();
      load  = 1'b1;
      value = 16'h7777;
      tick();
      load = 1'b0;
      check("pre_rst_ack", 11, 16'(load_ack), 16'h1);
      check("pre_rst_anode", 11, 16'(anode_n), 16'hD);
      rst = 1'b1;
      #1;
      check("async_rst_anode", 0, 16'(anode_n), 16'hF);
      check("async_rst_nibble", 0, 16'(nibble), 16'h0);
      check("async_rst_idx", 0, 16'(digit_idx), 16'h0);
      check("async_rst_ack", 0, 16'(load_ack), 16'h0);
      check("async_rst_fd", 0, 16'(frame_done), 16'h0);
      tick();
      rst = 1'b0;
      tick();
      // Reset cleared both buffers, so the restarted scan shows zero.
      run_frame(16'h0000, 4'b0001, 1'b0, 0, 16'h0, 1'b0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
